// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM for a shared-memory 32-bit MIPS datapath.
// Each instruction moves through fetch, decode, execute, memory and
// writeback. The controller drives the datapath strobes and mux selects
// for the current state. It stalls on mem_ready and traps on illegal opcodes.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_ne,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SUBI  = 6'b100111;
    localparam logic [5:0] OP_ANDI  = 6'b101111;
    localparam logic [5:0] OP_ORI   = 6'b110010;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    // State register; the opcode is captured once in DECODE so later IR changes are harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state selection; memory states hold until mem_ready, HALT holds until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_RTYPE:                          state_d = S_EXEC_R;
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    default:                           state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    // Moore output decode. Only the FETCH loads and the MEM_WR retire are gated by mem_ready.
    // Reset forces every output low, so no write strobe can fire in a reset cycle.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_write_ne   = 1'b0;
        pc_source     = 2'b00;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 4'd0;
        retire        = 1'b0;
        illegal       = 1'b0;
        state         = 4'd0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 4'd15;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (op_q)
                        OP_SUBI: alu_op = 4'd3;
                        OP_ANDI: alu_op = 4'd4;
                        OP_ORI:  alu_op = 4'd5;
                        default: alu_op = 4'd2;
                    endcase
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 4'd1;
                    pc_source     = 2'b01;
                    retire        = 1'b1;
                    pc_write_cond = (op_q == OP_BEQ);
                    pc_write_ne   = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                end
                S_HALT: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule
